// File: rtl/mips_regfile_pkg.sv
// Shared constants and encodings for the MIPS register file slice.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write-to-read forwarding).
package mips_regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ALU_W    = 64;
  localparam int unsigned REG_AW   = 5;

  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;
  localparam logic [REG_AW-1:0] RA_REG   = 5'd31;
  localparam logic [REG_AW-1:0] V0_REG   = 5'd2;

  // Destination register select
  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_RA   = 2'b10,
    DST_NONE = 2'b11
  } wdst_e;

  // Write-data source select
  typedef enum logic [2:0] {
    SEL_ALU  = 3'b000,
    SEL_MEM  = 3'b001,
    SEL_PC8  = 3'b010,
    SEL_HI   = 3'b011,
    SEL_LO   = 3'b100
  } wsel_e;

  // Return address for link instructions; wraps naturally at 2^32.
  function automatic logic [DATA_W-1:0] pc_plus8(input logic [DATA_W-1:0] pc);
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/mips_hilo.sv
// Hi/Lo multiply-divide result registers with independent load enables.
module mips_hilo
  import mips_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hi_en_i,
  input  logic              lo_en_i,
  input  logic [ALU_W-1:0]  alu_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  // Next-state: load upper/lower ALU halves when enabled, otherwise hold
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hi_en_i) begin
      hi_d = alu_i[63:32];
    end else begin
      hi_d = hi_q;
    end
    if (lo_en_i) begin
      lo_d = alu_i[31:0];
    end else begin
      lo_d = lo_q;
    end
  end

  // Hi/Lo state registers with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= {DATA_W{1'b0}};
      lo_q <= {DATA_W{1'b0}};
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mips_regfile.sv
// MIPS 32x32 general-purpose register file with registered two-port read,
// write-data/destination muxing, Hi/Lo registers and a debug V0 view.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a write on the
// same edge as a read of the same (non-zero) register is forwarded into the
// read outputs; when undefined, reads see the pre-edge contents.
module mips_regfile
  import mips_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        RegWriteEn,
  input  logic        RegReadEn,
  input  logic        HiEn,
  input  logic        LoEn,
  input  logic [1:0]  RegWriteDst,
  input  logic [2:0]  RegWriteDataSel,
  input  logic [31:0] RegPC,
  input  logic [31:0] ReadOutMem,
  input  logic [63:0] ALU,
  input  logic        Verify,
  output logic [31:0] RegOutput1,
  output logic [31:0] RegOutput2,
  output logic [31:0] V0
);

  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] hi_s, lo_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [DATA_W-1:0] v0_s;
  logic [REG_AW-1:0] rs_s, rt_s, rd_s, wr_addr_s;
  logic              wr_en_s;
  logic              unused_s;

  assign rs_s = Instruction[25:21];
  assign rt_s = Instruction[20:16];
  assign rd_s = Instruction[15:11];

  // Opcode/funct/shamt fields are decoded elsewhere in the pipeline
  assign unused_s = ^{Instruction[31:26], Instruction[10:0]};

  mips_hilo u_hilo (
    .clk     (clk),
    .reset   (reset),
    .hi_en_i (HiEn),
    .lo_en_i (LoEn),
    .alu_i   (ALU),
    .hi_o    (hi_s),
    .lo_o    (lo_s)
  );

  // Destination decode; writes aimed at $0 are dropped here so $0 stays zero
  always_comb begin
    wr_addr_s = ZERO_REG;
    wr_en_s   = 1'b0;
    case (RegWriteDst)
      DST_RT:   wr_addr_s = rt_s;
      DST_RD:   wr_addr_s = rd_s;
      DST_RA:   wr_addr_s = RA_REG;
      DST_NONE: wr_addr_s = ZERO_REG;
      default:  wr_addr_s = ZERO_REG;
    endcase
    if (RegWriteEn && (RegWriteDst != DST_NONE) && (wr_addr_s != ZERO_REG)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Write-data source mux; Hi/Lo sources are the pre-edge register values
  always_comb begin
    wr_data_s = {DATA_W{1'b0}};
    case (RegWriteDataSel)
      SEL_ALU: wr_data_s = ALU[31:0];
      SEL_MEM: wr_data_s = ReadOutMem;
      SEL_PC8: wr_data_s = pc_plus8(RegPC);
      SEL_HI:  wr_data_s = hi_s;
      SEL_LO:  wr_data_s = lo_s;
      default: wr_data_s = {DATA_W{1'b0}};
    endcase
  end

  // Read next-state: sample rs/rt when enabled, otherwise hold
  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (RegReadEn) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_en_s && (wr_addr_s == rs_s)) begin
        rd1_d = wr_data_s;
      end else begin
        rd1_d = gpr_q[rs_s];
      end
      if (wr_en_s && (wr_addr_s == rt_s)) begin
        rd2_d = wr_data_s;
      end else begin
        rd2_d = gpr_q[rt_s];
      end
`else
      rd1_d = gpr_q[rs_s];
      rd2_d = gpr_q[rt_s];
`endif
    end else begin
      rd1_d = rd1_q;
      rd2_d = rd2_q;
    end
  end

  // GPR array and read registers; reset overrides any write/read on the edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= {DATA_W{1'b0}};
      end
      rd1_q <= {DATA_W{1'b0}};
      rd2_q <= {DATA_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        gpr_q[wr_addr_s] <= wr_data_s;
      end
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  // Debug view of $v0, gated by Verify
  always_comb begin
    v0_s = {DATA_W{1'b0}};
    if (Verify) begin
      v0_s = gpr_q[V0_REG];
    end else begin
      v0_s = {DATA_W{1'b0}};
    end
  end

  assign RegOutput1 = rd1_q;
  assign RegOutput2 = rd2_q;
  assign V0         = v0_s;

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile.
module tb_mips_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction;
  logic        RegWriteEn;
  logic        RegReadEn;
  logic        HiEn;
  logic        LoEn;
  logic [1:0]  RegWriteDst;
  logic [2:0]  RegWriteDataSel;
  logic [31:0] RegPC;
  logic [31:0] ReadOutMem;
  logic [63:0] ALU;
  logic        Verify;
  logic [31:0] RegOutput1;
  logic [31:0] RegOutput2;
  logic [31:0] V0;

  int total_cnt;
  int bad_cnt;

  mips_regfile dut (
    .clk             (clk),
    .reset           (reset),
    .Instruction     (Instruction),
    .RegWriteEn      (RegWriteEn),
    .RegReadEn       (RegReadEn),
    .HiEn            (HiEn),
    .LoEn            (LoEn),
    .RegWriteDst     (RegWriteDst),
    .RegWriteDataSel (RegWriteDataSel),
    .RegPC           (RegPC),
    .ReadOutMem      (ReadOutMem),
    .ALU             (ALU),
    .Verify          (Verify),
    .RegOutput1      (RegOutput1),
    .RegOutput2      (RegOutput2),
    .V0              (V0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rs=4, rt=3, rd=5
  localparam logic [31:0] INSTR_A  = 32'h0083_2821;
  // rs=5, rt=0
  localparam logic [31:0] INSTR_R5 = 32'h00A0_0000;
  // rs=31, rt=0
  localparam logic [31:0] INSTR_RA = 32'h03E0_0000;
  // rs=0, rt=2
  localparam logic [31:0] INSTR_V0 = 32'h0002_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, return on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Write cycle: one edge with write enabled, read disabled
  task automatic do_write(input logic [31:0] instr, input logic [1:0] dst,
                          input logic [2:0] sel, input logic [63:0] alu);
    Instruction = instr; RegWriteDst = dst; RegWriteDataSel = sel; ALU = alu;
    RegWriteEn = 1'b1; RegReadEn = 1'b0;
    step();
    RegWriteEn = 1'b0;
  endtask

  // Read cycle: one edge with read enabled, write disabled
  task automatic do_read(input logic [31:0] instr);
    Instruction = instr; RegWriteEn = 1'b0; RegReadEn = 1'b1;
    step();
    RegReadEn = 1'b0;
  endtask

  initial begin
    logic [31:0] same_edge_exp;
    total_cnt = 0;
    bad_cnt   = 0;
    reset = 1'b1; Instruction = INSTR_A; RegWriteEn = 1'b0; RegReadEn = 1'b1;
    HiEn = 1'b0; LoEn = 1'b0; RegWriteDst = 2'b00; RegWriteDataSel = 3'b000;
    RegPC = 32'd0; ReadOutMem = 32'd0; ALU = 64'd0; Verify = 1'b1;
    step();
    step();
    chk("reset_out1", RegOutput1, 32'd0);
    chk("reset_out2", RegOutput2, 32'd0);
    chk("reset_v0", V0, 32'd0);
    reset = 1'b0;

    // ALU write to rt ($3)
    do_write(INSTR_A, 2'b00, 3'b000, 64'd5);
    do_read(INSTR_A);
    chk("alu_wr_rt", RegOutput2, 32'd5);
    chk("alu_rs_zero", RegOutput1, 32'd0);

    // Same-edge write and read of $3
`ifdef REGFILE_BYPASS_EN
    same_edge_exp = 32'd9;
`else
    same_edge_exp = 32'd5;
`endif
    Instruction = INSTR_A; RegWriteDst = 2'b00; RegWriteDataSel = 3'b000; ALU = 64'd9;
    RegWriteEn = 1'b1; RegReadEn = 1'b1;
    step();
    RegWriteEn = 1'b0; RegReadEn = 1'b0;
    chk("same_edge", RegOutput2, same_edge_exp);
    do_read(INSTR_A);
    chk("after_same_edge", RegOutput2, 32'd9);

    // Hold: write with read disabled leaves outputs alone
    do_write(INSTR_A, 2'b00, 3'b000, 64'd11);
    chk("read_hold", RegOutput2, 32'd9);

    // PC+8 and its wraparound
    RegPC = 32'd2;
    do_write(INSTR_A, 2'b00, 3'b010, 64'd0);
    do_read(INSTR_A);
    chk("pc_plus8", RegOutput2, 32'd10);
    RegPC = 32'hFFFF_FFFC;
    do_write(INSTR_A, 2'b00, 3'b010, 64'd0);
    do_read(INSTR_A);
    chk("pc_wrap", RegOutput2, 32'd4);

    // Memory load data
    ReadOutMem = 32'h0000_1234;
    do_write(INSTR_A, 2'b00, 3'b001, 64'd0);
    do_read(INSTR_A);
    chk("mem_data", RegOutput2, 32'h0000_1234);

    // Hi: first edge writes pre-edge Hi (0), second edge writes loaded Hi (2)
    HiEn = 1'b1; LoEn = 1'b1;
    do_write(INSTR_A, 2'b00, 3'b011, 64'h0000_0002_1111_1234);
    HiEn = 1'b0; LoEn = 1'b0;
    do_read(INSTR_A);
    chk("hi_pre_edge", RegOutput2, 32'd0);
    HiEn = 1'b1; LoEn = 1'b1;
    do_write(INSTR_A, 2'b00, 3'b011, 64'h0000_0002_1111_1234);
    HiEn = 1'b0; LoEn = 1'b0;
    do_read(INSTR_A);
    chk("hi_value", RegOutput2, 32'd2);
    do_write(INSTR_A, 2'b00, 3'b100, 64'd0);
    do_read(INSTR_A);
    chk("lo_value", RegOutput2, 32'h1111_1234);

    // Unused select code writes zero
    do_write(INSTR_A, 2'b00, 3'b101, 64'd77);
    do_read(INSTR_A);
    chk("sel_other", RegOutput2, 32'd0);

    // rd destination ($5) and $31 destination
    do_write(INSTR_A, 2'b01, 3'b000, 64'h77);
    do_read(INSTR_R5);
    chk("dst_rd", RegOutput1, 32'h77);
    do_write(INSTR_RA, 2'b10, 3'b000, 64'hABC);
    do_read(INSTR_RA);
    chk("dst_ra", RegOutput1, 32'hABC);
    // No-write destination leaves $31 alone
    do_write(INSTR_RA, 2'b11, 3'b000, 64'hDEAD);
    do_read(INSTR_RA);
    chk("dst_none", RegOutput1, 32'hABC);

    // Write aimed at $0 is discarded
    do_write(32'h0000_0000, 2'b01, 3'b000, 64'h55);
    do_read(32'h0000_0000);
    chk("zero_reg_rs", RegOutput1, 32'd0);
    chk("zero_reg_rt", RegOutput2, 32'd0);

    // V0 debug view
    do_write(INSTR_V0, 2'b00, 3'b000, 64'd7);
    Verify = 1'b1; #1;
    chk("v0_on", V0, 32'd7);
    Verify = 1'b0; #1;
    chk("v0_off", V0, 32'd0);

    // Reset overrides a pending write and read
    do_write(INSTR_A, 2'b00, 3'b000, 64'd5);
    do_read(INSTR_A);
    chk("pre_reset", RegOutput2, 32'd5);
    reset = 1'b1; RegWriteEn = 1'b1; RegReadEn = 1'b1; ALU = 64'd9;
    step();
    chk("reset_mid_out1", RegOutput1, 32'd0);
    chk("reset_mid_out2", RegOutput2, 32'd0);
    reset = 1'b0; RegWriteEn = 1'b0; RegReadEn = 1'b0;
    do_read(INSTR_A);
    chk("reset_discard", RegOutput2, 32'd0);
    Verify = 1'b1; #1;
    chk("reset_v0_clr", V0, 32'd0);
    Verify = 1'b0;
    // Hi and Lo were cleared too
    do_write(INSTR_A, 2'b00, 3'b011, 64'd0);
    do_read(INSTR_A);
    chk("reset_hi_clr", RegOutput2, 32'd0);
    do_write(INSTR_A, 2'b01, 3'b100, 64'd0);
    do_read(INSTR_R5);
    chk("reset_lo_clr", RegOutput1, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
